// File: rtl/isa_dma_arbiter_if.sv
// Bus-side signal bundle between the DMA/PIO arbiter and its neighbours.
// slave = the arbiter itself, master = register file / PIO / bus interface side.
interface isa_dma_arbiter_if #(
  parameter int CNT_W = 16
);
  logic [3:0]       drq;
  logic             cnt_load;
  logic [1:0]       cnt_ch;
  logic [CNT_W-1:0] cnt_value;
  logic             cnt_dir;
  logic [3:0]       done_clr;
  logic             pio_req;
  logic             pio_grant;
  logic [3:0]       dack;
  logic             aen;
  logic             iow;
  logic             ior;
  logic             data_load;
  logic             data_read;
  logic             tc;
  logic             xfer_done;
  logic [1:0]       xfer_ch;
  logic [3:0]       armed;
  logic [3:0]       done;

  modport slave (
    input  drq, cnt_load, cnt_ch, cnt_value, cnt_dir, done_clr, pio_req,
    output pio_grant, dack, aen, iow, ior, data_load, data_read, tc,
           xfer_done, xfer_ch, armed, done
  );

  modport master (
    output drq, cnt_load, cnt_ch, cnt_value, cnt_dir, done_clr, pio_req,
    input  pio_grant, dack, aen, iow, ior, data_load, data_read, tc,
           xfer_done, xfer_ch, armed, done
  );
endinterface

// File: rtl/isa_dma_arbiter.sv
// Shares the ISA bus between PIO and four 8237-style single-transfer DMA channels.
// Round-robin DMA arbitration with PIO/DMA alternation; every output decodes registered state.
module isa_dma_arbiter #(
  parameter int SYNC_STAGES = 2,
  parameter int SETUP_CYC   = 2,
  parameter int STROBE_CYC  = 6,
  parameter int HOLD_CYC    = 2,
  parameter int CNT_W       = 16
) (
  input  logic            clk,
  input  logic            reset,
  isa_dma_arbiter_if.slave bus
);
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_PIO    = 3'd1;
  localparam logic [2:0] ST_SETUP  = 3'd2;
  localparam logic [2:0] ST_STROBE = 3'd3;
  localparam logic [2:0] ST_HOLD   = 3'd4;
  localparam int PH_W = 8;

  logic [2:0]       r_state;
  logic [1:0]       r_ch;
  logic [1:0]       r_rr;
  logic [PH_W-1:0]  r_phase;
  logic             r_dir_lat;
  logic             r_tc_lat;
  logic             r_last_dma;
  logic [3:0]       r_sync [SYNC_STAGES];
  logic [CNT_W-1:0] r_count [4];
  logic [3:0]       r_dir;
  logic [3:0]       r_armed;
  logic [3:0]       r_done;

  logic [3:0] w_elig;
  logic       w_any;
  logic [1:0] w_pick;
  logic       w_setup_end;
  logic       w_strobe_end;
  logic       w_hold_end;
  logic       w_dma_bus;
  logic [3:0] w_load;
  logic [3:0] w_done_set;

  assign w_elig       = r_sync[SYNC_STAGES-1] & r_armed;
  assign w_setup_end  = (r_state == ST_SETUP)  && (r_phase == PH_W'(SETUP_CYC - 1));
  assign w_strobe_end = (r_state == ST_STROBE) && (r_phase == PH_W'(STROBE_CYC - 1));
  assign w_hold_end   = (r_state == ST_HOLD)   && (r_phase == PH_W'(HOLD_CYC - 1));
  assign w_dma_bus    = (r_state == ST_SETUP) || (r_state == ST_STROBE) || (r_state == ST_HOLD);

  // Scan downwards so the smallest offset from the pointer is the last (winning) assignment.
  always_comb begin
    w_any  = 1'b0;
    w_pick = r_rr;
    for (int i = 3; i >= 0; i--) begin
      if (w_elig[r_rr + 2'(i)]) begin
        w_any  = 1'b1;
        w_pick = r_rr + 2'(i);
      end
    end
  end

  always_comb begin
    for (int c = 0; c < 4; c++) begin
      w_load[c]     = bus.cnt_load && (bus.cnt_ch == 2'(c));
      w_done_set[c] = w_hold_end && (r_ch == 2'(c)) && (r_count[c] == '0) && !w_load[c];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_ch       <= 2'd0;
      r_rr       <= 2'd0;
      r_phase    <= '0;
      r_dir_lat  <= 1'b0;
      r_tc_lat   <= 1'b0;
      r_last_dma <= 1'b0;
      r_dir      <= '0;
      r_armed    <= '0;
      r_done     <= '0;
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
      for (int c = 0; c < 4; c++) r_count[c] <= '0;
    end else begin
      r_sync[0] <= bus.drq;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];

      case (r_state)
        ST_IDLE: begin
          if (w_any && !(bus.pio_req && r_last_dma)) begin
            r_state    <= ST_SETUP;
            r_ch       <= w_pick;
            r_dir_lat  <= r_dir[w_pick];
            r_tc_lat   <= (r_count[w_pick] == '0);
            r_phase    <= '0;
            r_last_dma <= 1'b1;
          end else if (bus.pio_req) begin
            r_state    <= ST_PIO;
            r_last_dma <= 1'b0;
          end
        end
        ST_PIO: begin
          if (!bus.pio_req) r_state <= ST_IDLE;
        end
        ST_SETUP: begin
          r_phase <= w_setup_end ? '0 : r_phase + 1'b1;
          if (w_setup_end) r_state <= ST_STROBE;
        end
        ST_STROBE: begin
          r_phase <= w_strobe_end ? '0 : r_phase + 1'b1;
          if (w_strobe_end) r_state <= ST_HOLD;
        end
        ST_HOLD: begin
          r_phase <= w_hold_end ? '0 : r_phase + 1'b1;
          if (w_hold_end) begin
            r_state <= ST_IDLE;
            r_rr    <= r_ch + 2'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      // A fresh load on the channel in service overrides the end-of-transfer update.
      for (int c = 0; c < 4; c++) begin
        if (w_load[c]) begin
          r_count[c] <= bus.cnt_value;
          r_dir[c]   <= bus.cnt_dir;
          r_armed[c] <= 1'b1;
        end else if (w_hold_end && (r_ch == 2'(c))) begin
          if (r_count[c] == '0) r_armed[c] <= 1'b0;
          else                  r_count[c] <= r_count[c] - 1'b1;
        end
        r_done[c] <= w_done_set[c] | (r_done[c] & ~bus.done_clr[c]);
      end
    end
  end

  assign bus.pio_grant = (r_state == ST_PIO);
  assign bus.aen       = w_dma_bus;
  assign bus.dack      = w_dma_bus ? (4'b0001 << r_ch) : 4'b0000;
  assign bus.iow       = (r_state == ST_STROBE) && r_dir_lat;
  assign bus.ior       = (r_state == ST_STROBE) && !r_dir_lat;
  assign bus.tc        = (r_state == ST_STROBE) && r_tc_lat;
  assign bus.data_load = (r_state == ST_SETUP) && (r_phase == '0) && r_dir_lat;
  assign bus.data_read = w_strobe_end && !r_dir_lat;
  assign bus.xfer_done = w_hold_end;
  assign bus.xfer_ch   = r_ch;
  assign bus.armed     = r_armed;
  assign bus.done      = r_done;
endmodule
